// File: rtl/text_console_pkg.sv
// Shared constants and types for the text console write-side sequencer:
// control codes, printable range, default attribute and FSM state encoding.
package text_console_pkg;

  localparam int ADDR_W = 10;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  localparam logic [7:0] DEFAULT_ATTR = 8'h07;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/text_console_ctrl_cursor.sv
// Cursor column/row counters for the text console. Operations are one-hot by
// intent; priority is home > newline > cr > back > advance.
module text_cursor #(
  parameter int COLS  = 30,
  parameter int ROWS  = 17,
  parameter int COL_W = 5,
  parameter int ROW_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             newline,
  input  logic             cr,
  input  logic             back,
  input  logic             home,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] row_inc;

  // Rows wrap to the top; there is no scrolling.
  assign row_inc = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (home) begin
      col_d = '0;
      row_d = '0;
    end else if (newline) begin
      col_d = '0;
      row_d = row_inc;
    end else if (cr) begin
      col_d = '0;
    end else if (back) begin
      if (col_q != '0) col_d = col_q - COL_W'(1);
    end else if (advance) begin
      if (col_q == COL_W'(COLS - 1)) begin
        col_d = '0;
        row_d = row_inc;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from before the clock edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: rtl/text_console_ctrl.sv
// Write-side sequencer for the 1024x16 text RAM port A: decodes a byte stream,
// tracks the cursor and runs the clear-screen fill. Optional build macro
// TEXT_CONSOLE_CLEAR_ON_RESET_EN starts with a clear (attr 8'h07) after reset.
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter int         COLS       = 30,
  parameter int         ROWS       = 17,
  parameter int         ROW_STRIDE = 32,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  attr,
  output logic [9:0]  ram_ada,
  output logic [15:0] ram_din,
  output logic        ram_cea,
  output logic        busy,
  output logic [4:0]  cur_col,
  output logic [4:0]  cur_row
);

  localparam int COL_W = $clog2(ROW_STRIDE);
  localparam int ROW_W = ADDR_W - COL_W;
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(ROWS * ROW_STRIDE - 1);

`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
  localparam state_e RST_STATE = CLEAR;
  localparam logic   RST_READY = 1'b0;
`else
  localparam state_e RST_STATE = RUN;
  localparam logic   RST_READY = 1'b1;
`endif

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [7:0]         fill_attr_q, fill_attr_d;
  logic [ADDR_W-1:0]  ram_ada_q, ram_ada_d;
  logic [15:0]        ram_din_q, ram_din_d;
  logic               ram_cea_q, ram_cea_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;

  logic               op_advance, op_newline, op_cr, op_back, op_home;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;

  text_cursor #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_cursor (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (op_advance),
    .newline (op_newline),
    .cr      (op_cr),
    .back    (op_back),
    .home    (op_home),
    .col     (col),
    .row     (row)
  );

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    fill_attr_d = fill_attr_q;
    ram_ada_d   = ram_ada_q;
    ram_din_d   = ram_din_q;
    ram_cea_d   = 1'b0;
    op_advance  = 1'b0;
    op_newline  = 1'b0;
    op_cr       = 1'b0;
    op_back     = 1'b0;
    op_home     = 1'b0;

    unique case (state_q)
      RUN: begin
        // in_ready_q mirrors RUN, so in_valid alone marks an accept here.
        if (in_valid) begin
          if (is_printable(in_data)) begin
            ram_ada_d  = {row, col};
            ram_din_d  = {attr, in_data};
            ram_cea_d  = 1'b1;
            op_advance = 1'b1;
          end else begin
            case (in_data)
              CC_CR: op_cr = 1'b1;
              CC_LF: op_newline = 1'b1;
              CC_BS: begin
                if (col != '0) begin
                  op_back   = 1'b1;
                  ram_ada_d = {row, col - COL_W'(1)};
                  ram_din_d = {attr, BLANK_CHAR};
                  ram_cea_d = 1'b1;
                end
              end
              CC_FF: begin
                fill_attr_d = attr;
                fill_cnt_d  = '0;
                state_d     = CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      CLEAR: begin
        // Fill covers the whole stride, off-screen columns included.
        ram_ada_d = fill_cnt_q;
        ram_din_d = {fill_attr_q, BLANK_CHAR};
        ram_cea_d = 1'b1;
        if (fill_cnt_q == FILL_LAST) begin
          op_home = 1'b1;
          state_d = RUN;
        end else begin
          fill_cnt_d = fill_cnt_q + ADDR_W'(1);
        end
      end
    endcase

    busy_d     = (state_d == CLEAR);
    in_ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      fill_cnt_q  <= '0;
      fill_attr_q <= DEFAULT_ATTR;
      ram_ada_q   <= '0;
      ram_din_q   <= '0;
      ram_cea_q   <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= RST_READY;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_attr_q <= fill_attr_d;
      ram_ada_q   <= ram_ada_d;
      ram_din_q   <= ram_din_d;
      ram_cea_q   <= ram_cea_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign ram_ada  = ram_ada_q;
  assign ram_din  = ram_din_q;
  assign ram_cea  = ram_cea_q;
  assign busy     = busy_q;
  assign in_ready = in_ready_q;
  assign cur_col  = 5'(col);
  assign cur_row  = 5'(row);

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed self-checking bench for text_console_ctrl: printable writes, cursor
// wrap, CR/LF/BS handling, clear-screen fill and reset during a clear.
module tb_text_console_ctrl;
  import text_console_pkg::*;

`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
  localparam logic RST_READY = 1'b0;
`else
  localparam logic RST_READY = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  attr = 8'h00;
  logic [9:0]  ram_ada;
  logic [15:0] ram_din;
  logic        ram_cea;
  logic        busy;
  logic [4:0]  cur_col;
  logic [4:0]  cur_row;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  text_console_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .attr     (attr),
    .ram_ada  (ram_ada),
    .ram_din  (ram_din),
    .ram_cea  (ram_cea),
    .busy     (busy),
    .cur_col  (cur_col),
    .cur_row  (cur_row)
  );

  // Presents one byte for one accept edge and returns at the following
  // negedge, where the resulting ram_* write (if any) is visible.
  task automatic send_byte(input logic [7:0] d, input logic [7:0] a);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end
    in_data  = d;
    attr     = a;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 700) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: in_ready=%b after %0d cycles, want 1", name, in_ready, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({ram_ada, ram_din, ram_cea, busy, in_ready, cur_col, cur_row} !==
        {10'd0, 16'h0000, 1'b0, 1'b0, RST_READY, 5'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_values: got ada=%0d din=%h cea=%b busy=%b rdy=%b col=%0d row=%0d, want 0 0000 0 0 %b 0 0",
               ram_ada, ram_din, ram_cea, busy, in_ready, cur_col, cur_row, RST_READY);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
    @(negedge clk);
    vectors++;
    if ({busy, in_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_clear_start: got busy=%b rdy=%b, want busy=1 rdy=0", busy, in_ready);
    end
    wait_ready("reset_clear_done");
`endif
  endtask

  task automatic test_print_a();
    send_byte(8'h41, 8'h1E);
    vectors++;
    if ({ram_cea, ram_ada, ram_din} !== {1'b1, 10'd0, 16'h1E41}) begin
      miscompares++;
      $display("FAIL print_a_write: got cea=%b ada=%0d din=%h, want cea=1 ada=0 din=1e41", ram_cea, ram_ada, ram_din);
    end
    vectors++;
    if ({cur_col, cur_row} !== {5'd1, 5'd0}) begin
      miscompares++;
      $display("FAIL print_a_cursor: got (%0d,%0d), want (1,0)", cur_col, cur_row);
    end
    @(negedge clk);
    vectors++;
    if (ram_cea !== 1'b0) begin
      miscompares++;
      $display("FAIL print_a_pulse: cea=%b one cycle later, want 0", ram_cea);
    end
  endtask

  task automatic test_row_wrap();
    logic [7:0] c;
    send_byte(CC_CR, 8'h00);
    vectors++;
    if ({ram_cea, cur_col, cur_row} !== {1'b0, 5'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL cr_home: got cea=%b (%0d,%0d), want cea=0 (0,0)", ram_cea, cur_col, cur_row);
    end
    for (int i = 0; i < 30; i++) begin
      c = 8'h41 + 8'(i % 26);
      send_byte(c, 8'h17);
      vectors++;
      if ({ram_cea, ram_ada, ram_din} !== {1'b1, 10'(i), 8'h17, c}) begin
        miscompares++;
        $display("FAIL row_fill_%0d: got cea=%b ada=%0d din=%h, want cea=1 ada=%0d din=17%h",
                 i, ram_cea, ram_ada, ram_din, i, c);
      end
    end
    vectors++;
    if ({cur_col, cur_row} !== {5'd0, 5'd1}) begin
      miscompares++;
      $display("FAIL col_wrap_cursor: got (%0d,%0d), want (0,1)", cur_col, cur_row);
    end
    send_byte(8'h78, 8'h17);
    vectors++;
    if ({ram_cea, ram_ada, ram_din} !== {1'b1, 10'd32, 16'h1778}) begin
      miscompares++;
      $display("FAIL next_row_write: got cea=%b ada=%0d din=%h, want cea=1 ada=32 din=1778", ram_cea, ram_ada, ram_din);
    end
  endtask

  task automatic test_controls();
    // From (1,1): 15 LFs reach row 16, then 5 glyphs reach (5,16).
    for (int i = 0; i < 15; i++) send_byte(CC_LF, 8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'h2E, 8'h07);
    vectors++;
    if ({cur_col, cur_row} !== {5'd5, 5'd16}) begin
      miscompares++;
      $display("FAIL setup_5_16: got (%0d,%0d), want (5,16)", cur_col, cur_row);
    end
    send_byte(CC_LF, 8'h00);
    vectors++;
    if ({ram_cea, cur_col, cur_row} !== {1'b0, 5'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL lf_row_wrap: got cea=%b (%0d,%0d), want cea=0 (0,0)", ram_cea, cur_col, cur_row);
    end
    for (int i = 0; i < 7; i++) send_byte(8'h2D, 8'h07);
    send_byte(CC_CR, 8'h00);
    vectors++;
    if ({ram_cea, cur_col, cur_row} !== {1'b0, 5'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL cr_col7: got cea=%b (%0d,%0d), want cea=0 (0,0)", ram_cea, cur_col, cur_row);
    end
    send_byte(8'h01, 8'h07);
    vectors++;
    if ({ram_cea, cur_col, cur_row} !== {1'b0, 5'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL discard_01: got cea=%b (%0d,%0d), want cea=0 (0,0)", ram_cea, cur_col, cur_row);
    end
    send_byte(8'h7F, 8'h07);
    vectors++;
    if ({ram_cea, cur_col, cur_row} !== {1'b0, 5'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL discard_7f: got cea=%b (%0d,%0d), want cea=0 (0,0)", ram_cea, cur_col, cur_row);
    end
  endtask

  task automatic test_backspace();
    send_byte(CC_LF, 8'h00);
    send_byte(CC_LF, 8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'h62, 8'h07);
    send_byte(CC_BS, 8'h4F);
    // Backspace blanks the new position (3,2): 2*32+3.
    vectors++;
    if ({ram_cea, ram_ada, ram_din} !== {1'b1, 10'd67, 16'h4F20}) begin
      miscompares++;
      $display("FAIL bs_write: got cea=%b ada=%0d din=%h, want cea=1 ada=67 din=4f20", ram_cea, ram_ada, ram_din);
    end
    vectors++;
    if ({cur_col, cur_row} !== {5'd3, 5'd2}) begin
      miscompares++;
      $display("FAIL bs_cursor: got (%0d,%0d), want (3,2)", cur_col, cur_row);
    end
    send_byte(CC_LF, 8'h00);
    send_byte(CC_BS, 8'h4F);
    vectors++;
    if ({ram_cea, cur_col, cur_row} !== {1'b0, 5'd0, 5'd3}) begin
      miscompares++;
      $display("FAIL bs_col0: got cea=%b (%0d,%0d), want cea=0 (0,3)", ram_cea, cur_col, cur_row);
    end
  endtask

  task automatic test_clear();
    int low_cycles = 0;
    int writes = 0;
    int bad = 0;
    int n = 0;
    logic [9:0] exp_ada = '0;
    send_byte(CC_FF, 8'h07);
    // Byte held by the sender for the whole fill.
    in_data  = 8'h5A;
    attr     = 8'h3C;
    in_valid = 1'b1;
    vectors++;
    if ({ram_cea, busy, in_ready} !== 3'b010) begin
      miscompares++;
      $display("FAIL ff_enter: got cea=%b busy=%b rdy=%b, want cea=0 busy=1 rdy=0", ram_cea, busy, in_ready);
    end
    while (!in_ready && n < 700) begin
      low_cycles++;
      @(posedge clk);
      @(negedge clk);
      n++;
      if (ram_cea) begin
        if (ram_ada !== exp_ada || ram_din !== 16'h0720) bad++;
        exp_ada++;
        writes++;
      end
    end
    vectors++;
    if (low_cycles != 544) begin
      miscompares++;
      $display("FAIL clear_ready_low: got %0d cycles, want 544", low_cycles);
    end
    vectors++;
    if (writes != 544 || bad != 0) begin
      miscompares++;
      $display("FAIL clear_writes: got %0d writes with %0d wrong, want 544 writes 0..543 of 0720", writes, bad);
    end
    vectors++;
    if ({ram_ada, busy, in_ready, cur_col, cur_row} !== {10'd543, 1'b0, 1'b1, 5'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL clear_done: got ada=%0d busy=%b rdy=%b (%0d,%0d), want 543 0 1 (0,0)",
               ram_ada, busy, in_ready, cur_col, cur_row);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if ({ram_cea, ram_ada, ram_din, cur_col, cur_row} !== {1'b1, 10'd0, 16'h3C5A, 5'd1, 5'd0}) begin
      miscompares++;
      $display("FAIL held_byte: got cea=%b ada=%0d din=%h (%0d,%0d), want cea=1 ada=0 din=3c5a (1,0)",
               ram_cea, ram_ada, ram_din, cur_col, cur_row);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    int pulses = 0;
    send_byte(CC_FF, 8'h07);
    while (!(ram_cea === 1'b1 && ram_ada === 10'd100) && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!(ram_cea === 1'b1 && ram_ada === 10'd100)) begin
      miscompares++;
      $display("FAIL reach_addr_100: got cea=%b ada=%0d after %0d cycles, want write at 100", ram_cea, ram_ada, n);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ram_ada, ram_din, ram_cea, busy, in_ready, cur_col, cur_row} !==
        {10'd0, 16'h0000, 1'b0, 1'b0, RST_READY, 5'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL midclear_reset: got ada=%0d din=%h cea=%b busy=%b rdy=%b (%0d,%0d), want 0 0000 0 0 %b (0,0)",
               ram_ada, ram_din, ram_cea, busy, in_ready, cur_col, cur_row, RST_READY);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ram_cea !== 1'b0) pulses++;
    end
    rst_n = 1'b1;
`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
    @(negedge clk);
    vectors++;
    if ({ram_cea, ram_ada, busy, in_ready} !== {1'b1, 10'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL restart_clear: got cea=%b ada=%0d busy=%b rdy=%b, want 1 0 1 0", ram_cea, ram_ada, busy, in_ready);
    end
    wait_ready("restart_clear_done");
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ram_cea !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) pulses++;
    end
`endif
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL abort_quiet: got %0d cycles with writes or busy, want 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_print_a();
    test_row_wrap();
    test_controls();
    test_backspace();
    test_clear();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
